sample_acq_ctrl: RTL and testbench



---
 rtl/sample_acq_ctrl.sv | 77 +++++++
 tb/tb_sample_acq_ctrl.sv | 90 +++++++++
 2 files changed

// File: rtl/sample_acq_ctrl.sv
// sample_acq_ctrl: strobe-driven ADC capture of N_SAMPLES words into a buffer RAM (ports: start/rate_sel/abort/adc_data in; sample_en, wr_en/wr_addr/wr_data, busy/done/aborted out)
module sample_acq_ctrl #(
  parameter int DIV_FAST  = 1000,
  parameter int DIV_SLOW  = 100000,
  parameter int N_SAMPLES = 1024,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rate_sel,
  input  logic              abort,
  input  logic [DATA_W-1:0] adc_data,
  output logic              sample_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  localparam int DMAX = DIV_SLOW > DIV_FAST ? DIV_SLOW : DIV_FAST;
  localparam int CW = $clog2(DMAX);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic rate_q, rate_d, sample_en_q, sample_en_d, wr_en_q, wr_en_d, aborted_q, aborted_d;
  logic run, last;
  logic [CW-1:0] div_cnt_q, div_cnt_d, div_lim;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  always_comb begin
    run = state_q == RUN;
    div_lim = rate_q ? CW'(DIV_SLOW - 1) : CW'(DIV_FAST - 1);
    last = wr_en_q && wr_addr_q == ADDR_W'(N_SAMPLES - 1);
    state_d = state_q == IDLE ? (start && !abort ? RUN : IDLE)
            : state_q == RUN ? (abort ? IDLE : last ? DONE : RUN) : IDLE;
    rate_d = state_q == IDLE && start && !abort ? rate_sel : rate_q;
    div_cnt_d = run && !abort && div_cnt_q != div_lim ? div_cnt_q + 1'b1 : '0;
    // the final write cycle must not launch one more strobe into DONE
    sample_en_d = run && !abort && !last && div_cnt_q == div_lim;
    wr_en_d = run && !abort && sample_en_q;
    wr_data_d = sample_en_q ? adc_data : wr_data_q;
    // address wraps to 0 after the last write, and is held at 0 outside RUN
    wr_addr_d = state_d == RUN ? wr_addr_q + ADDR_W'(wr_en_q) : '0;
    aborted_d = abort && state_q != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rate_q <= 1'b0;
      div_cnt_q <= '0;
      sample_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q <= rate_d;
      div_cnt_q <= div_cnt_d;
      sample_en_q <= sample_en_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      aborted_q <= aborted_d;
    end
  end
  // abort takes effect in its own cycle on the write and completion pulses
  assign sample_en = sample_en_q;
  assign wr_en = wr_en_q && !abort;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE && !abort;
  assign aborted = aborted_q;
endmodule

// File: tb/tb_sample_acq_ctrl.sv
// tb_sample_acq_ctrl: scenario table, reset sequences and random traffic against an arithmetic timing model
module tb_sample_acq_ctrl;
  localparam int DF = 4, DS = 10, N = 8;
  logic clk = 0, rst = 1, start = 0, rate_sel = 0, abort = 0;
  logic [11:0] adc_data = 0;
  logic sample_en, wr_en, busy, done, aborted;
  logic [2:0] wr_addr;
  logic [11:0] wr_data;
  sample_acq_ctrl #(.DIV_FAST(DF), .DIV_SLOW(DS), .N_SAMPLES(N), .ADDR_W(3), .DATA_W(12)) dut (
    .clk(clk), .rst(rst), .start(start), .rate_sel(rate_sel), .abort(abort), .adc_data(adc_data),
    .sample_en(sample_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .aborted(aborted)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int cyc = 0, t0 = 0, dv = DF, n_wr = 0, n_done = 0, n_ab = 0;
  bit active = 0, ab_pend = 0;
  logic [11:0] prev_adc = 0;
  typedef struct {bit rate; bit tog; bit spam; int abort_at; int e_wr; int e_done; int e_ab;} row_t;
  row_t rows[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // model: an accepted start at cycle c opens a run at t0=c+1; with k=cycle-t0,
  // strobes at k=j*DIV, writes at k=j*DIV+1 (j=1..N), done at k=N*DIV+2
  task automatic step(input logic s, input logic r, input logic a, input logic [11:0] d);
    int k, nw;
    logic e_se, e_wr, e_done;
    logic [2:0] e_addr;
    @(negedge clk);
    start = s; rate_sel = r; abort = a; adc_data = d;
    #1;
    k = cyc - t0;
    e_se = active && k > 0 && k % dv == 0 && k / dv <= N;
    e_wr = active && !a && k > 1 && (k - 1) % dv == 0 && (k - 1) / dv <= N;
    e_done = active && !a && k == N * dv + 2;
    nw = k >= 2 ? ((k - 2) / dv < N ? (k - 2) / dv : N) : 0;
    e_addr = active ? 3'(nw % N) : 3'd0;
    chk("outputs", 32'({sample_en, wr_en, busy, done, aborted, wr_addr}),
        32'({e_se, e_wr, active, e_done, ab_pend, e_addr}));
    if (e_wr) chk("wr_data", 32'(wr_data), 32'(prev_adc));
    n_wr += int'(wr_en); n_done += int'(done); n_ab += int'(aborted);
    if (active) begin
      ab_pend = a;
      if (a || k == N * dv + 2) active = 0;
    end else begin
      ab_pend = 0;
      if (s && !a) begin active = 1; t0 = cyc + 1; dv = r ? DS : DF; end
    end
    prev_adc = d;
    cyc++;
  endtask
  task automatic run_row(input row_t rw);
    n_wr = 0; n_done = 0; n_ab = 0;
    for (int s = 0; s < 90; s++)
      step(s == 0 || (rw.spam && s < 30 && s % 5 == 2), rw.rate ^ (rw.tog && s > 3 && (s / 3) % 2 == 1),
           s == rw.abort_at, 12'($urandom));
    chk("row_writes", 32'(n_wr), 32'(rw.e_wr));
    chk("row_done", 32'(n_done), 32'(rw.e_done));
    chk("row_aborted", 32'(n_ab), 32'(rw.e_ab));
  endtask
  initial begin
    rows = '{'{0, 0, 0, -1, 8, 1, 0}, '{1, 1, 0, -1, 8, 1, 0}, '{0, 0, 1, -1, 8, 1, 0},
             '{0, 0, 0, 15, 3, 0, 1}, '{0, 0, 0, -1, 8, 1, 0}, '{0, 0, 0, 34, 7, 0, 1},
             '{0, 0, 0, 35, 8, 0, 1}, '{0, 0, 0, 0, 0, 0, 0}};
    repeat (2) @(negedge clk);
    rst = 0;
    #1 chk("reset_state", 32'({sample_en, wr_en, busy, done, aborted, wr_addr, wr_data}), 32'd0);
    repeat (20) step(0, 0, 0, 12'($urandom));
    chk("idle_wr_data", 32'(wr_data), 32'd0);
    foreach (rows[i]) run_row(rows[i]);
    step(1, 0, 0, 12'h123);
    repeat (15) step(0, 0, 0, 12'($urandom));
    @(negedge clk);
    rst = 1;
    #1 chk("async_reset", 32'({sample_en, wr_en, busy, done, aborted, wr_addr, wr_data}), 32'd0);
    active = 0; ab_pend = 0;
    @(negedge clk);
    rst = 0;
    run_row(rows[0]);
    repeat (3000)
      step($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0, 12'($urandom));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
